// File: rtl/layer_header_fetch.sv
// Pipeline-side scanner of the layer header store: walks layers bottom-up,
// drops disabled headers and offers enabled ones over a valid/ready handshake.
module layer_header_fetch #(
  parameter int unsigned NUM_LAYERS   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ENABLE_BIT   = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         startScan,
  input  logic         abortScan,
  output logic [4:0]   readLayerPipe,
  input  logic [127:0] layerInfo,
  output logic         hdrValid,
  input  logic         hdrReady,
  output logic [4:0]   hdrLayer,
  output logic [127:0] hdrData,
  output logic         scanBusy,
  output logic         scanDone,
  output logic [5:0]   enabledCount
);

  localparam int unsigned LAYER_W = 5;
  localparam int unsigned WAIT_W  = 2;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned DATA_W  = 128;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              r_state;
  logic [LAYER_W-1:0]  r_rd_layer;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_delivered;
  logic                r_hdr_valid;
  logic [LAYER_W-1:0]  r_hdr_layer;
  logic [DATA_W-1:0]   r_hdr_data;
  logic                r_scan_busy;
  logic                r_scan_done;
  logic [CNT_W-1:0]    r_enabled_cnt;

  state_t              w_state_nxt;
  logic [LAYER_W-1:0]  w_rd_layer_nxt;
  logic [WAIT_W-1:0]   w_wait_cnt_nxt;
  logic [CNT_W-1:0]    w_delivered_nxt;
  logic                w_hdr_valid_nxt;
  logic [LAYER_W-1:0]  w_hdr_layer_nxt;
  logic [DATA_W-1:0]   w_hdr_data_nxt;
  logic                w_scan_busy_nxt;
  logic                w_scan_done_nxt;
  logic [CNT_W-1:0]    w_enabled_cnt_nxt;

  logic                w_layer_enabled;
  logic                w_last_layer;
  logic                w_sample;

  assign w_layer_enabled = layerInfo[ENABLE_BIT];
  assign w_last_layer    = (r_rd_layer == LAST_LAYER);
  assign w_sample        = (r_wait_cnt == WAIT_LAST);

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_rd_layer    <= '0;
      r_wait_cnt    <= '0;
      r_delivered   <= '0;
      r_hdr_valid   <= 1'b0;
      r_hdr_layer   <= '0;
      r_hdr_data    <= '0;
      r_scan_busy   <= 1'b0;
      r_scan_done   <= 1'b0;
      r_enabled_cnt <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rd_layer    <= w_rd_layer_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_delivered   <= w_delivered_nxt;
      r_hdr_valid   <= w_hdr_valid_nxt;
      r_hdr_layer   <= w_hdr_layer_nxt;
      r_hdr_data    <= w_hdr_data_nxt;
      r_scan_busy   <= w_scan_busy_nxt;
      r_scan_done   <= w_scan_done_nxt;
      r_enabled_cnt <= w_enabled_cnt_nxt;
    end
  end

  // Next-state logic; abort outranks every transition, including a transfer.
  always_comb begin
    w_state_nxt       = r_state;
    w_rd_layer_nxt    = r_rd_layer;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_delivered_nxt   = r_delivered;
    w_hdr_valid_nxt   = r_hdr_valid;
    w_hdr_layer_nxt   = r_hdr_layer;
    w_hdr_data_nxt    = r_hdr_data;
    w_scan_busy_nxt   = r_scan_busy;
    w_scan_done_nxt   = 1'b0;
    w_enabled_cnt_nxt = r_enabled_cnt;

    if (r_state != IDLE && abortScan) begin
      w_state_nxt     = IDLE;
      w_hdr_valid_nxt = 1'b0;
      w_scan_busy_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (startScan && !abortScan) begin
            w_state_nxt     = FETCH;
            w_rd_layer_nxt  = '0;
            w_wait_cnt_nxt  = '0;
            w_delivered_nxt = '0;
            w_scan_busy_nxt = 1'b1;
          end
        end
        FETCH: begin
          if (!w_sample) begin
            w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
          end else if (w_layer_enabled) begin
            w_hdr_data_nxt  = layerInfo;
            w_hdr_layer_nxt = r_rd_layer;
            w_hdr_valid_nxt = 1'b1;
            w_delivered_nxt = r_delivered + CNT_W'(1);
            w_state_nxt     = PRESENT;
          end else if (w_last_layer) begin
            w_state_nxt = DONE;
          end else begin
            w_rd_layer_nxt = r_rd_layer + LAYER_W'(1);
            w_wait_cnt_nxt = '0;
          end
        end
        PRESENT: begin
          if (hdrReady) begin
            w_hdr_valid_nxt = 1'b0;
            if (w_last_layer) begin
              w_state_nxt = DONE;
            end else begin
              w_rd_layer_nxt = r_rd_layer + LAYER_W'(1);
              w_wait_cnt_nxt = '0;
              w_state_nxt    = FETCH;
            end
          end
        end
        DONE: begin
          w_scan_done_nxt   = 1'b1;
          w_enabled_cnt_nxt = r_delivered;
          w_scan_busy_nxt   = 1'b0;
          w_state_nxt       = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign readLayerPipe = r_rd_layer;
  assign hdrValid      = r_hdr_valid;
  assign hdrLayer      = r_hdr_layer;
  assign hdrData       = r_hdr_data;
  assign scanBusy      = r_scan_busy;
  assign scanDone      = r_scan_done;
  assign enabledCount  = r_enabled_cnt;

endmodule

// File: tb/tb_layer_header_fetch.sv
// Directed bench for layer_header_fetch: a behavioural header store feeds the
// DUT and a scoreboard queue holds the headers each scan should deliver.
module tb_layer_header_fetch;

  localparam int unsigned NL = 32;

  typedef struct packed {
    logic [4:0]   layer;
    logic [127:0] data;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         startScan;
  logic         abortScan;
  logic [4:0]   readLayerPipe;
  logic [127:0] layerInfo;
  logic         hdrValid;
  logic         hdrReady;
  logic [4:0]   hdrLayer;
  logic [127:0] hdrData;
  logic         scanBusy;
  logic         scanDone;
  logic [5:0]   enabledCount;

  logic [127:0] store [NL];
  exp_t         sb_q [$];
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  int           xfer_cnt = 0;

  layer_header_fetch #(
    .NUM_LAYERS  (32),
    .READ_LATENCY(1),
    .ENABLE_BIT  (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startScan    (startScan),
    .abortScan    (abortScan),
    .readLayerPipe(readLayerPipe),
    .layerInfo    (layerInfo),
    .hdrValid     (hdrValid),
    .hdrReady     (hdrReady),
    .hdrLayer     (hdrLayer),
    .hdrData      (hdrData),
    .scanBusy     (scanBusy),
    .scanDone     (scanDone),
    .enabledCount (enabledCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Header store model with a one-clock read latency.
  always @(posedge clk) layerInfo <= store[readLayerPipe];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_enabled();
    exp_t e;
    for (int i = 0; i < NL; i++) begin
      if (store[i][0]) begin
        e.layer = 5'(i);
        e.data  = store[i];
        sb_q.push_back(e);
      end
    end
  endtask

  // One clock; a transfer seen before the edge is scored against the queue.
  task automatic step();
    logic         xfer;
    logic [4:0]   lay;
    logic [127:0] dat;
    exp_t         e;
    xfer = hdrValid && hdrReady && !abortScan && reset;
    lay  = hdrLayer;
    dat  = hdrData;
    @(posedge clk);
    #1;
    if (scanDone) done_cnt++;
    if (xfer) begin
      xfer_cnt++;
      check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("xfer_layer", 128'(lay), 128'(e.layer));
        check("xfer_data", dat, e.data);
      end
    end
  endtask

  task automatic start_scan();
    startScan = 1'b1;
    step();
    startScan = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!hdrValid && n < budget) begin
      step();
      n++;
    end
    check("valid_timeout", 128'(hdrValid), 128'(1));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!scanDone && n < budget) begin
      step();
      n++;
    end
    check("done_timeout", 128'(scanDone), 128'(1));
  endtask

  initial begin
    int  cyc;
    bit  seen_valid;
    reset = 1'b0;
    startScan = 1'b0;
    abortScan = 1'b0;
    hdrReady = 1'b0;
    for (int i = 0; i < NL; i++) store[i] = '0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", 128'({hdrValid, hdrLayer, scanBusy, scanDone, enabledCount, readLayerPipe}), '0);
    check("rst_data", hdrData, '0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_outs", 128'({hdrValid, hdrLayer, scanBusy, scanDone, enabledCount, readLayerPipe}), '0);
    end

    // Sparse scan: layers 0, 5, 31 enabled
    for (int i = 0; i < NL; i++) store[i] = rnd128() & ~128'(1);
    store[0]  = rnd128() | 128'(1);
    store[5]  = rnd128() | 128'(1);
    store[31] = rnd128() | 128'(1);
    hdrReady = 1'b1;
    done_cnt = 0;
    xfer_cnt = 0;
    push_enabled();
    start_scan();
    check("sparse_busy", 128'(scanBusy), 128'(1));
    wait_done(300);
    repeat (3) step();
    check("sparse_xfers", 128'(xfer_cnt), 128'(3));
    check("sparse_sb_empty", 128'(sb_q.size()), 128'(0));
    check("sparse_done_once", 128'(done_cnt), 128'(1));
    check("sparse_enabled_cnt", 128'(enabledCount), 128'(3));
    check("sparse_busy_end", 128'(scanBusy), 128'(0));

    // Backpressure: only layer 2 enabled, consumer stalls 10 cycles
    for (int i = 0; i < NL; i++) store[i] = rnd128() & ~128'(1);
    store[2] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5;
    hdrReady = 1'b0;
    xfer_cnt = 0;
    push_enabled();
    start_scan();
    wait_valid(100);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", 128'(hdrValid), 128'(1));
      check("bp_layer", 128'(hdrLayer), 128'(2));
      check("bp_data", hdrData, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5);
    end
    hdrReady = 1'b1;
    step();
    check("bp_valid_drop", 128'(hdrValid), 128'(0));
    check("bp_rd_advance", 128'(readLayerPipe), 128'(3));
    wait_done(300);
    check("bp_xfers", 128'(xfer_cnt), 128'(1));
    check("bp_enabled_cnt", 128'(enabledCount), 128'(1));

    // Abort while layer 7 is pending, then restart from layer 0
    for (int i = 0; i < NL; i++) store[i] = rnd128() | 128'(1);
    hdrReady = 1'b1;
    done_cnt = 0;
    push_enabled();
    start_scan();
    cyc = 0;
    while (!(hdrValid && hdrLayer == 5'd7) && cyc < 200) begin
      step();
      cyc++;
    end
    check("abort_reach_l7", 128'(hdrValid && hdrLayer == 5'd7), 128'(1));
    abortScan = 1'b1;
    step();
    abortScan = 1'b0;
    check("abort_valid", 128'(hdrValid), 128'(0));
    check("abort_busy", 128'(scanBusy), 128'(0));
    check("abort_sb_left", 128'(sb_q.size()), 128'(25));
    sb_q.delete();
    repeat (5) step();
    check("abort_no_done", 128'(done_cnt), 128'(0));
    check("abort_enabled_kept", 128'(enabledCount), 128'(1));
    hdrReady = 1'b0;
    push_enabled();
    start_scan();
    wait_valid(100);
    check("restart_layer0", 128'(hdrLayer), 128'(0));
    check("restart_data0", hdrData, store[0]);
    abortScan = 1'b1;
    step();
    abortScan = 1'b0;
    sb_q.delete();

    // No enabled layers: done after 32*2+1 cycles
    for (int i = 0; i < NL; i++) store[i] = rnd128() & ~128'(1);
    hdrReady = 1'b1;
    done_cnt = 0;
    seen_valid = 1'b0;
    start_scan();
    cyc = 0;
    while (!scanDone && cyc < 200) begin
      step();
      cyc++;
      if (hdrValid) seen_valid = 1'b1;
    end
    check("none_latency", 128'(cyc), 128'(65));
    check("none_no_valid", 128'(seen_valid), 128'(0));
    check("none_enabled_cnt", 128'(enabledCount), 128'(0));
    step();
    check("none_done_pulse", 128'(scanDone), 128'(0));

    // Ignored restart during FETCH, then async reset during PRESENT
    store[20] = store[20] | 128'(1);
    push_enabled();
    start_scan();
    repeat (9) step();
    startScan = 1'b1;
    step();
    startScan = 1'b0;
    check("restart_ignored_rd", 128'(readLayerPipe), 128'(5));
    check("restart_ignored_busy", 128'(scanBusy), 128'(1));
    hdrReady = 1'b0;
    wait_valid(100);
    check("mid_layer20", 128'(hdrLayer), 128'(20));
    done_cnt = 0;
    #3;
    reset = 1'b0;
    #1;
    check("arst_valid", 128'(hdrValid), 128'(0));
    check("arst_busy", 128'(scanBusy), 128'(0));
    check("arst_rd", 128'(readLayerPipe), 128'(0));
    check("arst_data", hdrData, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb_q.delete();
    hdrReady = 1'b1;
    repeat (5) step();
    check("arst_no_done", 128'(done_cnt), 128'(0));
    check("arst_idle_valid", 128'(hdrValid), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_header_fetch.md
Name: layer_header_fetch

Overview:
- Pipeline-side reader of the layer header store. On each frame-start pulse it scans layer indices 0..NUM_LAYERS-1 in ascending order (layer 0 = bottom) by driving the store's pipeline read address.
- It captures each 128-bit header, drops disabled layers, and hands enabled headers to the compositing pipeline over a valid/ready handshake.
- It sits between the layer header store (pipeline read port) and the pixel pipeline front end.

Parameters:
- NUM_LAYERS, 32: layers scanned per frame (1..32).
- READ_LATENCY, 1: clocks from a readLayerPipe change to a valid layerInfo (0..3).
- ENABLE_BIT, 0: bit of layerInfo[15:0] (register 0) that marks the layer enabled.

Ports:
- clk  in  1  GPU clock, rising edge.
- reset  in  1  Asynchronous, active-low (0 = reset, 1 = run).
- startScan  in  1  Single-cycle pulse; begins a scan.
- abortScan  in  1  Level; terminates the current scan.
- readLayerPipe  out  5  Layer index presented to the header store pipeline port.
- layerInfo  in  128  Header data returned by the store.
- hdrValid  out  1  Header offered to the pipeline.
- hdrReady  in  1  Pipeline accepts the header.
- hdrLayer  out  5  Layer index of the offered header.
- hdrData  out  128  Offered header, registered copy of layerInfo.
- scanBusy  out  1  High from scan start until DONE/abort.
- scanDone  out  1  One-cycle pulse when a scan completes normally.
- enabledCount  out  6  Headers delivered in the most recent completed scan.

Behaviour:
- Reset (async, reset=0): state IDLE.
  - readLayerPipe=0, hdrValid=0, hdrLayer=0, hdrData=0.
  - scanBusy=0, scanDone=0, enabledCount=0; internal wait and delivered counters = 0.
- All outputs are registered.
- States: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - startScan=1 -> FETCH next cycle, with readLayerPipe=0, waitCnt=0, deliveredCnt=0, scanBusy=1.
  - startScan while not IDLE is ignored.
- FETCH:
  - waitCnt increments each cycle until waitCnt==READ_LATENCY.
  - In that cycle layerInfo is sampled:
    - Enable bit set -> hdrData<=layerInfo, hdrLayer<=readLayerPipe, hdrValid<=1, deliveredCnt+1, -> PRESENT.
    - Enable bit clear, not last layer -> readLayerPipe+1, waitCnt<=0, stay FETCH.
    - Enable bit clear, last layer (readLayerPipe==NUM_LAYERS-1) -> DONE.
  - A disabled layer therefore costs READ_LATENCY+1 cycles.
- PRESENT:
  - hdrValid stays high; hdrData and hdrLayer are held stable until the transfer.
  - Transfer occurs on a cycle with hdrValid&&hdrReady.
  - On transfer: hdrValid<=0; if last layer -> DONE, else readLayerPipe+1, waitCnt<=0, -> FETCH.
  - hdrReady high before hdrValid has no effect.
  - Minimum spacing between headers is READ_LATENCY+2 cycles.
- DONE (one cycle):
  - scanDone=1, enabledCount<=deliveredCnt, scanBusy<=0, -> IDLE.
- Layer index never wraps: the scan stops at NUM_LAYERS-1. readLayerPipe holds its last value in IDLE.
- Zero enabled layers: no hdrValid; scanDone is asserted READ_LATENCY+1 cycles per layer after the scan starts (NUM_LAYERS*(READ_LATENCY+1)+1 cycles after startScan).
- abortScan=1 in any non-IDLE state:
  - Next cycle: IDLE, hdrValid=0, scanBusy=0.
  - No scanDone; enabledCount is unchanged.
  - abortScan has priority over a same-cycle transfer. The header is treated as not delivered, though the consumer may have sampled it.
- startScan and abortScan together in IDLE: abort wins, stay IDLE.
- Header contents may change mid-scan because controller writes are unsynchronized. Each header is captured atomically in its sample cycle. There is no consistency guarantee across layers.
- Async reset mid-scan returns every output to its reset value immediately. No scanDone is generated.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, no startScan -> all outputs 0, state IDLE for 20 cycles.
- Sparse scan: enable bits set for layers 0, 5, 31, hdrReady=1 -> hdrLayer sequence 0, 5, 31, with hdrData equal to the store contents; scanDone pulses once; enabledCount=3.
- Backpressure: layer 2 enabled (hdrData=128'h…A5), hdrReady=0 for 10 cycles then 1 -> hdrValid stays high with hdrData/hdrLayer stable for all 10 cycles; exactly one transfer; readLayerPipe advances to 3 afterwards.
- No enabled layers, READ_LATENCY=1 -> hdrValid never rises; scanDone 65 cycles after startScan; enabledCount=0.
- Abort: all 32 layers enabled, abortScan=1 while hdrLayer=7 is pending -> hdrValid=0 and scanBusy=0 next cycle; no scanDone; enabledCount keeps its previous value; a new startScan restarts at layer 0.
- Reset mid-scan plus ignored restart: startScan re-pulsed during FETCH is ignored, with the scan continuing from the current layer; then reset=0 during PRESENT -> hdrValid and scanBusy drop to 0 asynchronously, readLayerPipe=0.
